// File: rtl/mem_8192x64_arb.sv
// rtl/mem_8192x64_arb.sv - Init sequencer and round-robin two-requester arbiter for the 8192x64 RW SRAM macro
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   req{0,1}_valid/ready   request handshake; ready is the combinational grant
//   req{0,1}_write/addr/wdata/wmask  request payload, held stable until ready
//   resp{0,1}_valid        read data for that requester is on resp_data this cycle
//   resp_data              shared read data, straight from mem_rdata
//   init_done              array zero-filled (or init skipped) and accepting requests
//   mem_*                  drive the macro RW0 port; mem_clk is the clock itself
module mem_8192x64_arb #(
    parameter int DEPTH         = 8192,
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 64,
    parameter int MASK_W        = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [MASK_W-1:0] req0_wmask,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [MASK_W-1:0] req1_wmask,
    output logic              resp0_valid,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_clk,
    output logic              mem_wmode,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_grant;
    logic              resp0_q;
    logic              resp1_q;
    logic              in_init;
    logic              in_run;
    logic              grant0;
    logic              grant1;

    // Reset is synchronous, so the registers only settle at the next edge;
    // gating with reset keeps every output quiet for the whole reset cycle.
    assign in_init = !reset && (state == ST_INIT);
    assign in_run  = !reset && (state == ST_RUN);

    // Round-robin: on contention the requester that did not win last time goes.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (in_run) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            init_cnt   <= '0;
            last_grant <= 1'b1;
            resp0_q    <= 1'b0;
            resp1_q    <= 1'b0;
        end else begin
            resp0_q <= grant0 && !req0_write;
            resp1_q <= grant1 && !req1_write;
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign resp0_valid = resp0_q && !reset;
    assign resp1_valid = resp1_q && !reset;
    assign resp_data   = mem_rdata;
    assign init_done   = in_run;
    assign mem_clk     = clock;

    always_comb begin
        mem_en    = 1'b0;
        mem_wmode = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (in_init) begin
            mem_en    = 1'b1;
            mem_wmode = 1'b1;
            mem_addr  = init_cnt;
            mem_wmask = '1;
        end else if (grant0) begin
            mem_en    = 1'b1;
            mem_wmode = req0_write;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
            mem_wmask = req0_wmask;
        end else if (grant1) begin
            mem_en    = 1'b1;
            mem_wmode = req1_write;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
            mem_wmask = req1_wmask;
        end
    end

endmodule
